uart_boot_loader: RTL

- Hardware MMIO initiator for the UART MMIO peripheral: polls STATUS, drains RX bytes, and assembles a length-prefixed program image into 32-bit words.
- Writes each word to instruction memory, then returns ACK/NAK through the TX register.
- Sits between the system bus UART window and the instruction-memory write port; holds the CPU in reset until the load completes.

---
 rtl/uart_mmio_pkg.sv | 11 +
 rtl/uart_word_assembler.sv | 32 +++
 rtl/uart_boot_loader.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: UART MMIO register offsets, status bits, response bytes and loader states
package uart_mmio_pkg;
  localparam logic [31:0] RX_OFF = 32'h0;
  localparam logic [31:0] TX_OFF = 32'h4;
  localparam logic [31:0] STATUS_OFF = 32'h8;
  localparam int RX_VALID = 0;
  localparam int TX_BUSY = 1;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  typedef enum logic [2:0] {IDLE, RX_POLL, RX_READ, MEM_WR, TX_POLL, TX_WRITE, FIN} state_t;
endpackage

// File: rtl/uart_word_assembler.sv
// uart_word_assembler: little-endian byte shift-in to 32-bit words with word-complete pulse and optional running XOR (UART_LOADER_CSUM_EN)
module uart_word_assembler (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  din,
`ifdef UART_LOADER_CSUM_EN
  input  logic        sum_en,
  output logic [7:0]  sum,
`endif
  output logic [31:0] word,
  output logic [31:0] word_next,
  output logic        word_done
);
  logic [1:0] cnt;
  assign word_next = {din, word[31:8]};
  assign word_done = shift && cnt == 2'd3;
  always_ff @(posedge clk)
    if (!rstn || clr) begin
      word <= '0;
      cnt <= '0;
    end else if (shift) begin
      word <= word_next;
      cnt <= cnt + 2'd1;
    end
`ifdef UART_LOADER_CSUM_EN
  always_ff @(posedge clk)
    if (!rstn || clr) sum <= '0;
    else if (shift && sum_en) sum <= sum ^ din;
`endif
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: UART MMIO length-prefixed image loader into instruction memory (UART_LOADER_CSUM_EN adds trailing XOR check)
module uart_boot_loader
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter logic [31:0] LOAD_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 4096
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  output logic [31:0] o_mmio_addr,
  output logic [7:0]  o_mmio_data_out,
  input  logic [7:0]  i_mmio_data_in,
  output logic        o_mmio_we,
  output logic        o_mmio_re,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_we,
  input  logic        i_mem_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_cpu_rstn
);
  state_t state, state_nx;
  logic [31:0] word, word_next, n, word_idx;
  logic word_done, have_len, nak, done, err, shift, len_bad, last;
`ifdef UART_LOADER_CSUM_EN
  logic [7:0] sum;
  logic csum_phase;
  assign shift = state == RX_READ && !csum_phase;
`else
  assign shift = state == RX_READ;
`endif
  assign len_bad = word_next == 32'd0 || word_next > 32'(MAX_WORDS);
  assign last = word_idx + 32'd1 == n;
  uart_word_assembler u_asm (
    .clk(i_clk),
    .rstn(i_rstn),
    .clr(state == IDLE && i_start),
    .shift(shift),
    .din(i_mmio_data_in),
`ifdef UART_LOADER_CSUM_EN
    .sum_en(have_len),
    .sum(sum),
`endif
    .word(word),
    .word_next(word_next),
    .word_done(word_done)
  );
  always_ff @(posedge i_clk)
    if (!i_rstn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (i_start) state_nx = RX_POLL;
      RX_POLL:  if (i_mmio_data_in[RX_VALID]) state_nx = RX_READ;
`ifdef UART_LOADER_CSUM_EN
      RX_READ:  state_nx = csum_phase || (word_done && !have_len && len_bad) ? TX_POLL :
                           word_done && have_len ? MEM_WR : RX_POLL;
      MEM_WR:   if (i_mem_ready) state_nx = RX_POLL;
`else
      RX_READ:  state_nx = word_done && !have_len && len_bad ? TX_POLL :
                           word_done && have_len ? MEM_WR : RX_POLL;
      MEM_WR:   if (i_mem_ready) state_nx = last ? TX_POLL : RX_POLL;
`endif
      TX_POLL:  if (!i_mmio_data_in[TX_BUSY]) state_nx = TX_WRITE;
      TX_WRITE: state_nx = FIN;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk)
    if (!i_rstn) begin
      have_len <= 1'b0;
      n <= '0;
      word_idx <= '0;
      nak <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
`ifdef UART_LOADER_CSUM_EN
      csum_phase <= 1'b0;
`endif
    end else begin
      if (state == IDLE && i_start) begin
        have_len <= 1'b0;
        word_idx <= '0;
        nak <= 1'b0;
        done <= 1'b0;
        err <= 1'b0;
`ifdef UART_LOADER_CSUM_EN
        csum_phase <= 1'b0;
`endif
      end
      if (state == RX_READ && word_done && !have_len) begin
        nak <= len_bad;
        have_len <= !len_bad;
        n <= word_next;
      end
      if (state == MEM_WR && i_mem_ready) begin
        word_idx <= word_idx + 32'd1;
`ifdef UART_LOADER_CSUM_EN
        csum_phase <= last;
`endif
      end
`ifdef UART_LOADER_CSUM_EN
      if (state == RX_READ && csum_phase) nak <= i_mmio_data_in != sum;
`endif
      if (state == FIN) begin
        done <= !nak;
        err <= nak;
      end
    end
  assign o_mmio_re = state == RX_POLL || state == RX_READ || state == TX_POLL;
  assign o_mmio_we = state == TX_WRITE;
  assign o_mmio_addr = BASE_ADDR + (state == RX_READ ? RX_OFF : state == TX_WRITE ? TX_OFF : STATUS_OFF);
  assign o_mmio_data_out = state == TX_WRITE ? (nak ? NAK : ACK) : 8'h00;
  assign o_mem_we = state == MEM_WR;
  assign o_mem_addr = LOAD_ADDR + {word_idx[29:0], 2'b00};
  assign o_mem_wdata = word;
  assign o_busy = state != IDLE && state != FIN;
  assign o_done = done;
  assign o_err = err;
  assign o_cpu_rstn = state == IDLE && done;
endmodule
